// File: rtl/boot_mem_loader.sv
// Boot memory loader: clears the memory to FILL, accepts a streamed boot image,
// then hands the memory to the CPU as a mirrored RAM until the next reset.
module boot_mem_loader #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 16,
    parameter int                DEPTH  = 256,
    parameter int                RD_LAT = 0,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    input  logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     cpu_run,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     ovf,
    output logic [1:0]               dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] CNT_TOP = (IDX_W + 1)'(DEPTH - 1);
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(DEPTH);

    // Loader handshake: a word moves on any rising edge where ld_valid and
    // ld_ready are both high; ld_valid may drop at any time to stall.
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        clr_idx;
    logic [IDX_W-1:0]        idx;
    logic                    xfer;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem [DEPTH];

    assign idx       = addr[IDX_W-1:0];
    assign xfer      = ld_valid && ld_ready;
    assign dbg_state = state;

    generate
        if (ADDR_W > IDX_W) begin : g_mirror
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = S_LOAD;
            S_LOAD:  if (xfer && (ld_last || ld_count == CNT_TOP)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        cpu_run   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_idx;
        mem_wdata = FILL;
        case (state)
            S_CLEAR: mem_we = 1'b1;
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = xfer;
                mem_waddr = ld_count[IDX_W-1:0];
                mem_wdata = ld_data;
            end
            S_RUN: begin
                cpu_run   = 1'b1;
                mem_we    = wr_en;
                mem_waddr = idx;
                mem_wdata = wr_data;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_idx  <= '0;
            ld_count <= '0;
            ovf      <= 1'b0;
        end else begin
            if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (xfer && ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
            // Filling the last slot without ld_last means the image was too big.
            if (xfer && !ld_last && ld_count == CNT_TOP) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    generate
        if (RD_LAT == 0) begin : g_rd_comb
            assign rd_data  = cpu_run ? mem[idx] : '0;
            assign rd_valid = cpu_run;
        end else begin : g_rd_reg
            logic [DATA_W-1:0] rd_q;
            logic              rv_q;
            // Registered read samples the array before a same-edge write lands.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_q <= '0;
                    rv_q <= 1'b0;
                end else begin
                    rd_q <= cpu_run ? mem[idx] : '0;
                    rv_q <= cpu_run;
                end
            end
            assign rd_data  = rd_q;
            assign rd_valid = rv_q;
        end
    endgenerate
endmodule

// File: tb/tb_boot_mem_loader.sv
// Bench for boot_mem_loader: three instances (256/lat0, 16/lat0, 16/lat1),
// one exercised at a time while the others idle in reset or RUN.
module tb_boot_mem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic        ld_valid, ld_last, wr_en;
    logic [7:0]  ld_data, wr_data;
    logic [15:0] addr;

    logic       ld_ready_a, rd_valid_a, cpu_run_a, ovf_a;
    logic [7:0] rd_data_a;
    logic [8:0] ld_count_a;
    logic [1:0] state_a;
    logic       ld_ready_b, rd_valid_b, cpu_run_b, ovf_b;
    logic [7:0] rd_data_b;
    logic [4:0] ld_count_b;
    logic [1:0] state_b;
    logic       ld_ready_c, rd_valid_c, cpu_run_c, ovf_c;
    logic [7:0] rd_data_c;
    logic [4:0] ld_count_c;
    logic [1:0] state_c;

    boot_mem_loader #(.DEPTH(256), .RD_LAT(0)) u_a (
        .clk(clk), .reset(rst_a), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
        .ld_data(ld_data), .ld_last(ld_last), .addr(addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_data(wr_data), .cpu_run(cpu_run_a),
        .ld_count(ld_count_a), .ovf(ovf_a), .dbg_state(state_a));

    boot_mem_loader #(.DEPTH(16), .RD_LAT(0), .FILL(8'h5A)) u_b (
        .clk(clk), .reset(rst_b), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
        .ld_data(ld_data), .ld_last(ld_last), .addr(addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_data(wr_data), .cpu_run(cpu_run_b),
        .ld_count(ld_count_b), .ovf(ovf_b), .dbg_state(state_b));

    boot_mem_loader #(.DEPTH(16), .RD_LAT(1), .FILL(8'h3C)) u_c (
        .clk(clk), .reset(rst_c), .ld_valid(ld_valid), .ld_ready(ld_ready_c),
        .ld_data(ld_data), .ld_last(ld_last), .addr(addr), .rd_data(rd_data_c),
        .rd_valid(rd_valid_c), .wr_en(wr_en), .wr_data(wr_data), .cpu_run(cpu_run_c),
        .ld_count(ld_count_c), .ovf(ovf_c), .dbg_state(state_c));

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_a [256];
    logic [7:0] model_b [16];
    logic [7:0] model_c [16];
    logic [7:0] img [6];

    // ---------------- driver tasks ----------------
    task automatic hold_all_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        addr = '0; wr_en = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input int sel, output int cycles);
        cycles = 0;
        while (!(sel == 0 ? ld_ready_a : sel == 1 ? ld_ready_b : ld_ready_c) && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ld_valid = 1'b1; wr_en = 1'b1; ld_data = 8'hFF; wr_data = 8'hFF;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cpu_run_a, ld_ready_a, rd_valid_a, ovf_a, ld_count_a, rd_data_a, state_a} !== '0)
            $display("FAIL reset_a: got run=%b rdy=%b rv=%b ovf=%b cnt=%0d rd=%h st=%0d expected all zero",
                     cpu_run_a, ld_ready_a, rd_valid_a, ovf_a, ld_count_a, rd_data_a, state_a);
        else n_pass++;
        n_checks++;
        if ({cpu_run_b, ld_ready_b, rd_valid_b, ovf_b, ld_count_b, rd_data_b, state_b} !== '0)
            $display("FAIL reset_b: got run=%b rdy=%b cnt=%0d rd=%h expected all zero",
                     cpu_run_b, ld_ready_b, ld_count_b, rd_data_b);
        else n_pass++;
        n_checks++;
        if ({cpu_run_c, ld_ready_c, rd_valid_c, ovf_c, ld_count_c, rd_data_c, state_c} !== '0)
            $display("FAIL reset_c: got run=%b rdy=%b rv=%b cnt=%0d rd=%h expected all zero",
                     cpu_run_c, ld_ready_c, rd_valid_c, ld_count_c, rd_data_c);
        else n_pass++;
        hold_all_reset();
    endtask

    task automatic test_load_run();
        int         cyc;
        logic [7:0] got, e;
        logic [15:0] ad [6];
        ad = '{16'h0003, 16'h0010, 16'h0103, 16'hFF03, 16'h0000, 16'h0005};
        img = '{8'hA9, 8'h03, 8'h38, 8'hE9, 8'h02, 8'h18};
        foreach (model_a[i]) model_a[i] = 8'h00;
        rst_a = 1'b1;
        wait_ready(0, cyc);
        n_checks++;
        if (cyc !== 256) $display("FAIL clear_cycles_a: got %0d expected 256", cyc); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            send(img[i], i == 5);
            model_a[i] = img[i];
        end
        n_checks++;
        if ({cpu_run_a, rd_valid_a, ld_ready_a, ovf_a, ld_count_a} !== {4'b1100, 9'd6})
            $display("FAIL run_entry_a: got run=%b rv=%b rdy=%b ovf=%b cnt=%0d expected 1 1 0 0 6",
                     cpu_run_a, rd_valid_a, ld_ready_a, ovf_a, ld_count_a);
        else n_pass++;
        for (int i = 0; i < 14; i++) begin
            addr = (i < 6) ? ad[i] : 16'($urandom_range(0, 65535));
            exp_q.push_back(model_a[addr[7:0]]);
            #1;
            got = rd_data_a;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL read_a addr=%h: got %h expected %h", addr, got, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_gaps();
        int         cyc;
        logic [7:0] got, e;
        foreach (model_b[i]) model_b[i] = 8'h5A;
        wr_en = 1'b1; wr_data = 8'h77; addr = 16'h0005;
        rst_b = 1'b1;
        wait_ready(1, cyc);
        n_checks++;
        if (cyc !== 16) $display("FAIL clear_cycles_b: got %0d expected 16", cyc); else n_pass++;
        ld_valid = 1'b1; ld_data = 8'h11; ld_last = 1'b0;
        @(negedge clk);
        ld_valid = 1'b0; ld_data = 8'hEE;
        @(negedge clk);
        n_checks++;
        if (ld_count_b !== 5'd1) $display("FAIL gap_stall_b: got %0d expected 1", ld_count_b); else n_pass++;
        @(negedge clk);
        ld_valid = 1'b1; ld_data = 8'h22; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0; wr_en = 1'b0;
        model_b[0] = 8'h11; model_b[1] = 8'h22;
        n_checks++;
        if ({cpu_run_b, ld_count_b} !== {1'b1, 5'd2})
            $display("FAIL gap_done_b: got run=%b cnt=%0d expected 1 2", cpu_run_b, ld_count_b);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            addr = {12'($urandom_range(0, 4095)), 4'(i)};
            exp_q.push_back(model_b[i]);
            #1;
            got = rd_data_b;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL gap_read_b idx=%0d: got %h expected %h", i, got, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        int         cyc;
        logic [7:0] d, got, e;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        foreach (model_b[i]) model_b[i] = 8'h5A;
        wait_ready(1, cyc);
        n_checks++;
        if (cyc !== 16) $display("FAIL reclear_cycles_b: got %0d expected 16", cyc); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                n_checks++;
                if ({ovf_b, state_b, ld_count_b} !== {1'b0, 2'd1, 5'd15})
                    $display("FAIL pre_ovf_b: got ovf=%b st=%0d cnt=%0d expected 0 1 15", ovf_b, state_b, ld_count_b);
                else n_pass++;
            end
            d = 8'($urandom_range(0, 255));
            send(d, 1'b0);
            model_b[i] = d;
        end
        n_checks++;
        if ({ovf_b, cpu_run_b, ld_count_b} !== {2'b11, 5'd16})
            $display("FAIL ovf_b: got ovf=%b run=%b cnt=%0d expected 1 1 16", ovf_b, cpu_run_b, ld_count_b);
        else n_pass++;
        for (int i = 15; i >= 0; i--) begin
            addr = {12'($urandom_range(0, 4095)), 4'(i)};
            exp_q.push_back(model_b[i]);
            #1;
            got = rd_data_b;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL ovf_read_b idx=%0d: got %h expected %h", i, got, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_write_lat0();
        logic [3:0] k;
        logic [7:0] v, got, e;
        for (int i = 0; i < 4; i++) begin
            k = 4'($urandom_range(0, 15));
            v = 8'($urandom_range(0, 255));
            addr = {12'($urandom_range(0, 4095)), k};
            wr_en = 1'b1; wr_data = v;
            exp_q.push_back(model_b[k]);
            #1;
            got = rd_data_b;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL wr_before_b idx=%0d: got %h expected %h", k, got, e); else n_pass++;
            model_b[k] = v;
            exp_q.push_back(model_b[k]);
            @(posedge clk);
            #1;
            got = rd_data_b;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL wr_after_b idx=%0d: got %h expected %h", k, got, e); else n_pass++;
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic test_lat1();
        int         cyc;
        logic [7:0] e;
        foreach (model_c[i]) model_c[i] = 8'h3C;
        img = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00};
        rst_c = 1'b1;
        wait_ready(2, cyc);
        n_checks++;
        if (cyc !== 16) $display("FAIL clear_cycles_c: got %0d expected 16", cyc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            send(img[i], i == 3);
            model_c[i] = img[i];
        end
        n_checks++;
        if ({cpu_run_c, rd_valid_c, rd_data_c} !== {2'b10, 8'h00})
            $display("FAIL lat1_entry_c: got run=%b rv=%b rd=%h expected 1 0 00", cpu_run_c, rd_valid_c, rd_data_c);
        else n_pass++;
        addr = 16'h0020;
        wr_en = 1'b1; wr_data = 8'h55;
        exp_q.push_back(model_c[0]);
        @(negedge clk);
        wr_en = 1'b0;
        model_c[0] = 8'h55;
        e = exp_q.pop_front();
        n_checks++;
        if ({rd_valid_c, rd_data_c} !== {1'b1, e})
            $display("FAIL rdw_old_c: got rv=%b rd=%h expected 1 %h", rd_valid_c, rd_data_c, e);
        else n_pass++;
        exp_q.push_back(model_c[0]);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data_c !== e) $display("FAIL lat1_read_c addr=%h: got %h expected %h", addr, rd_data_c, e);
            else n_pass++;
            addr = 16'($urandom_range(0, 65535));
            exp_q.push_back(model_c[addr[3:0]]);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data_c !== e) $display("FAIL lat1_tail_c: got %h expected %h", rd_data_c, e); else n_pass++;
    endtask

    task automatic test_reset_midload();
        int         cyc;
        logic [7:0] got, e;
        rst_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_run_a, rd_valid_a, ld_count_a, state_a} !== '0)
            $display("FAIL reset_from_run_a: got run=%b rv=%b cnt=%0d st=%0d expected 0 0 0 0",
                     cpu_run_a, rd_valid_a, ld_count_a, state_a);
        else n_pass++;
        rst_a = 1'b1;
        wait_ready(0, cyc);
        send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b0);
        n_checks++;
        if (ld_count_a !== 9'd3) $display("FAIL partial_cnt_a: got %0d expected 3", ld_count_a); else n_pass++;
        rst_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ld_ready_a, ld_count_a} !== '0)
            $display("FAIL midload_reset_a: got rdy=%b cnt=%0d expected 0 0", ld_ready_a, ld_count_a);
        else n_pass++;
        rst_a = 1'b1;
        foreach (model_a[i]) model_a[i] = 8'h00;
        wait_ready(0, cyc);
        n_checks++;
        if (cyc !== 256) $display("FAIL reclear_cycles_a: got %0d expected 256", cyc); else n_pass++;
        send(8'h11, 1'b0); send(8'h22, 1'b1);
        model_a[0] = 8'h11; model_a[1] = 8'h22;
        n_checks++;
        if ({cpu_run_a, ld_count_a} !== {1'b1, 9'd2})
            $display("FAIL reload_a: got run=%b cnt=%0d expected 1 2", cpu_run_a, ld_count_a);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            addr = 16'(i);
            exp_q.push_back(model_a[i]);
            #1;
            got = rd_data_a;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL reload_read_a idx=%0d: got %h expected %h", i, got, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        hold_all_reset();
        test_reset();
        test_load_run();
        test_gaps();
        test_overflow();
        test_write_lat0();
        test_lat1();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
